game_progress: RTL and testbench
================================

// Module: game_progress
// PURPOSE
// - Sits directly downstream of the mine-check stage and consumes its explode / mark_flag / defuse pulses.
// - Keeps per-cell revealed and flag bitmaps, the flags-left counter, a seconds timer and the game FSM (IDLE/PLAY/WON/LOST).
// - Its maps and state drive the board renderer and the status/timer display.
// PARAMETERS
// - CLK_HZ   65_000_000  clock cycles per elapsed second (tests use 10)
// - MAX_SEC  999         saturation value of elapsed_s
// PORTS
// - clk          in   1          system clock; all state updates on posedge clk
// - rst          in   1          synchronous reset, active-high
// - level        in   2          0 none, 1 easy 8x8/10 mines, 2 medium 10x10/20 mines, 3 hard 16x16/40 mines
// - start        in   1          1-cycle pulse: begin a game from IDLE
// - new_game     in   1          1-cycle pulse: return to IDLE from WON/LOST
// - ind_x_in     in   4          cell column, same value as fed to the mine-check stage
// - ind_y_in     in   4          cell row, same value as fed to the mine-check stage
// - explode      in   1          registered pulse from mine-check: mine hit
// - mark_flag    in   1          registered pulse from mine-check: flag request
// - defuse       in   1          registered pulse from mine-check: safe cell opened
// - game_state   out  2          0 IDLE, 1 PLAY, 2 WON, 3 LOST
// - revealed_map out  [15:0][15:0]  [x][y]=1 when cell opened
// - flag_map     out  [15:0][15:0]  [x][y]=1 when cell flagged
// - flags_left   out  6          mines minus placed flags
// - elapsed_s    out  10         seconds in PLAY, saturating at MAX_SEC
// BEHAVIOUR
// - Reset: game_state=IDLE, both maps=0, flags_left=0, elapsed_s=0, prescaler=0, latched level=0, revealed count=0.
//   Reset in any state wins over every other input.
// - Index alignment:
//   - ind_x_in/ind_y_in are registered once internally.
//   - A pulse at cycle n applies to the indices presented at cycle n-1, matching the mine-check latency.
// - IDLE:
//   - On start with level!=0: latch level (dim, mine count), clear maps, flags_left=mines, elapsed_s=0, go to PLAY next cycle.
//   - start with level==0 is ignored.
//   - All pulses are ignored.
// - PLAY:
//   - Latched level is fixed; changes on the level input are ignored until the next start.
//   - Pulse priority when several are asserted: explode > defuse > mark_flag.
//   - Pulses with ind_x or ind_y >= dim are ignored.
//   - explode on unflagged cell: set revealed bit; game_state=LOST at n+1.
//   - explode on flagged cell: ignored.
//   - defuse on unrevealed, unflagged cell: set revealed bit, revealed count +1, both visible at n+1.
//   - defuse on a revealed or flagged cell: no change.
//   - mark_flag on unrevealed cell toggles the flag:
//     - Setting requires flags_left>0, then flags_left-1; with flags_left==0 the set is ignored.
//     - Clearing gives flags_left+1.
//   - mark_flag on a revealed cell: ignored.
//   - Win: when revealed count == dim*dim - mines, game_state=WON one cycle after the count update (n+2).
//   - Win check takes priority over a same-cycle pulse.
// - Timer:
//   - Prescaler counts 0..CLK_HZ-1 in PLAY only.
//   - On wrap, elapsed_s +1, saturating at MAX_SEC; the prescaler keeps running.
//   - Prescaler resets to 0 on entry to PLAY.
// - WON/LOST:
//   - Maps, flags_left and elapsed_s are frozen; all pulses and start are ignored.
//   - new_game gives IDLE next cycle; maps and counters stay as they are until the next start clears them.
//   - new_game in IDLE/PLAY: ignored.
// - Widths: revealed count is 8 bits (max 216). Counters never wrap.
// TESTING
// - rst, level=1, start -> PLAY at +1, flags_left=10, maps 0; rst mid-PLAY -> IDLE, all outputs 0 next cycle.
// - Easy: defuse on (2,3) -> revealed_map[2][3]=1 at +1; repeat defuse -> count unchanged; explode on (5,5) -> LOST at +1, later pulses ignored.
// - Easy: 54 distinct defuse pulses -> WON two cycles after the last pulse; elapsed_s frozen afterwards.
// - Flags: 10 mark_flag on distinct cells -> flags_left=0; 11th ignored; re-flag a cell -> cleared, flags_left=1; defuse/explode on a flagged cell -> no change.
// - Priority/range: explode+defuse same cycle -> LOST; level=1, defuse at (9,0) -> ignored; level=3, (15,15) accepted.
// - CLK_HZ=10: 10000 cycles in PLAY -> elapsed_s=999 (saturated); new_game from WON -> IDLE, then start -> elapsed_s=0.

Source files
------------

// File: rtl/game_progress_if.sv
// Handshake bundle between the mine-check stage, the game_progress block and its display consumers.
interface game_progress_if;
   logic [1:0]        level;
   logic              start;
   logic              new_game;
   logic [3:0]        ind_x_in;
   logic [3:0]        ind_y_in;
   logic              explode;
   logic              mark_flag;
   logic              defuse;
   logic [1:0]        game_state;
   logic [15:0][15:0] revealed_map;
   logic [15:0][15:0] flag_map;
   logic [5:0]        flags_left;
   logic [9:0]        elapsed_s;

   modport master (
      output level, start, new_game, ind_x_in, ind_y_in, explode, mark_flag, defuse,
      input  game_state, revealed_map, flag_map, flags_left, elapsed_s
   );

   modport slave (
      input  level, start, new_game, ind_x_in, ind_y_in, explode, mark_flag, defuse,
      output game_state, revealed_map, flag_map, flags_left, elapsed_s
   );
endinterface

// File: rtl/game_progress.sv
// Game bookkeeping: revealed/flag bitmaps, flags-left counter, seconds timer and IDLE/PLAY/WON/LOST FSM.
module game_progress #(
   parameter int CLK_HZ  = 65_000_000,
   parameter int MAX_SEC = 999
) (
   input  logic            clk,
   input  logic            rst,
   game_progress_if.slave  bus
);
   localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

   typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, WON = 2'd2, LOST = 2'd3} state_t;

   state_t            state, state_nx;
   logic [3:0]        ind_x_p0, ind_y_p0;
   logic [1:0]        lvl;
   logic [15:0][15:0] rev_map, flg_map;
   logic [5:0]        flags_left;
   logic [9:0]        elapsed;
   logic [PW-1:0]     presc;
   logic [7:0]        rev_cnt;

   function automatic logic [4:0] level_dim(input logic [1:0] l);
      case (l)
         2'd1:    level_dim = 5'd8;
         2'd2:    level_dim = 5'd10;
         2'd3:    level_dim = 5'd16;
         default: level_dim = 5'd0;
      endcase
   endfunction

   function automatic logic [5:0] level_mines(input logic [1:0] l);
      case (l)
         2'd1:    level_mines = 6'd10;
         2'd2:    level_mines = 6'd20;
         2'd3:    level_mines = 6'd40;
         default: level_mines = 6'd0;
      endcase
   endfunction

   // Safe cells to open before the game is won: dim*dim - mines.
   function automatic logic [7:0] win_target(input logic [1:0] l);
      case (l)
         2'd1:    win_target = 8'd54;
         2'd2:    win_target = 8'd80;
         2'd3:    win_target = 8'd216;
         default: win_target = 8'd0;
      endcase
   endfunction

   function automatic logic [9:0] sat_inc_sec(input logic [9:0] v);
      if (v >= 10'(MAX_SEC)) sat_inc_sec = 10'(MAX_SEC);
      else                   sat_inc_sec = v + 10'd1;
   endfunction

   // Stage p0: indices delayed to line up with the registered mine-check pulses
   always_ff @(posedge clk) begin
      ind_x_p0 <= bus.ind_x_in;
      ind_y_p0 <= bus.ind_y_in;
   end

   logic [4:0] dim;
   logic       in_range, cell_rev, cell_flg, win, act, start_ok;
   logic       do_explode, do_defuse, do_flag_set, do_flag_clr;

   always_comb begin
      dim         = level_dim(lvl);
      in_range    = ({1'b0, ind_x_p0} < dim) && ({1'b0, ind_y_p0} < dim);
      cell_rev    = rev_map[ind_x_p0][ind_y_p0];
      cell_flg    = flg_map[ind_x_p0][ind_y_p0];
      win         = (rev_cnt == win_target(lvl));
      act         = (state == PLAY) && !win && in_range;
      start_ok    = (state == IDLE) && bus.start && (bus.level != 2'd0);
      do_explode  = act && bus.explode && !cell_flg;
      do_defuse   = act && !bus.explode && bus.defuse && !cell_rev && !cell_flg;
      do_flag_set = act && !bus.explode && !bus.defuse && bus.mark_flag &&
                    !cell_rev && !cell_flg && (flags_left != 6'd0);
      do_flag_clr = act && !bus.explode && !bus.defuse && bus.mark_flag &&
                    !cell_rev && cell_flg;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (start_ok) state_nx = PLAY;
         PLAY: begin
            if (win)             state_nx = WON;
            else if (do_explode) state_nx = LOST;
         end
         WON, LOST: if (bus.new_game) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.game_state   = state;
      bus.revealed_map = rev_map;
      bus.flag_map     = flg_map;
      bus.flags_left   = flags_left;
      bus.elapsed_s    = elapsed;
   end

   // Stage p1: board maps, counters and timer
   always_ff @(posedge clk) begin
      if (rst) begin
         lvl        <= 2'd0;
         rev_map    <= '0;
         flg_map    <= '0;
         flags_left <= 6'd0;
         elapsed    <= 10'd0;
         presc      <= '0;
         rev_cnt    <= 8'd0;
      end else begin
         if (start_ok) begin
            lvl        <= bus.level;
            rev_map    <= '0;
            flg_map    <= '0;
            flags_left <= level_mines(bus.level);
            elapsed    <= 10'd0;
            presc      <= '0;
            rev_cnt    <= 8'd0;
         end
         if (state == PLAY) begin
            if (presc == PW'(CLK_HZ - 1)) begin
               presc   <= '0;
               elapsed <= sat_inc_sec(elapsed);
            end else begin
               presc <= presc + 1'b1;
            end
            if (do_explode || do_defuse) rev_map[ind_x_p0][ind_y_p0] <= 1'b1;
            if (do_defuse) rev_cnt <= rev_cnt + 8'd1;
            if (do_flag_set) begin
               flg_map[ind_x_p0][ind_y_p0] <= 1'b1;
               flags_left                  <= flags_left - 6'd1;
            end
            if (do_flag_clr) begin
               flg_map[ind_x_p0][ind_y_p0] <= 1'b0;
               flags_left                  <= flags_left + 6'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_game_progress.sv
// Bench for game_progress: rule-level reference model compared every cycle, plus directed literal checks.
module tb_game_progress;
   localparam int CLK_HZ  = 10;
   localparam int MAX_SEC = 999;

   logic clk = 1'b0;
   logic rst;
   game_progress_if bus ();

   game_progress #(.CLK_HZ(CLK_HZ), .MAX_SEC(MAX_SEC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Reference model: plain arrays and integer counters derived from the game rules
   bit m_rev  [16][16];
   bit m_flag [16][16];
   int m_state = 0, m_lvl = 0, m_fl = 0, m_cnt = 0, m_play = 0, m_el = 0;
   int px = 0, py = 0;

   function automatic int dim_of(input int l);
      return (l == 1) ? 8 : (l == 2) ? 10 : (l == 3) ? 16 : 0;
   endfunction
   function automatic int mines_of(input int l);
      return (l == 1) ? 10 : (l == 2) ? 20 : (l == 3) ? 40 : 0;
   endfunction

   always @(posedge clk) begin
      int d;
      d = dim_of(m_lvl);
      if (rst) begin
         m_state = 0; m_lvl = 0; m_fl = 0; m_cnt = 0; m_play = 0; m_el = 0;
         foreach (m_rev[i, j]) begin m_rev[i][j] = 0; m_flag[i][j] = 0; end
      end else begin
         case (m_state)
            0: if (bus.start && bus.level != 0) begin
               m_lvl = bus.level; m_fl = mines_of(m_lvl); m_cnt = 0; m_play = 0; m_el = 0;
               foreach (m_rev[i, j]) begin m_rev[i][j] = 0; m_flag[i][j] = 0; end
               m_state = 1;
            end
            1: begin
               m_play++;
               m_el = (m_play / CLK_HZ > MAX_SEC) ? MAX_SEC : m_play / CLK_HZ;
               if (m_cnt == d * d - mines_of(m_lvl)) m_state = 2;
               else if (px < d && py < d) begin
                  if (bus.explode) begin
                     if (!m_flag[px][py]) begin m_rev[px][py] = 1; m_state = 3; end
                  end else if (bus.defuse) begin
                     if (!m_rev[px][py] && !m_flag[px][py]) begin m_rev[px][py] = 1; m_cnt++; end
                  end else if (bus.mark_flag && !m_rev[px][py]) begin
                     if (m_flag[px][py]) begin m_flag[px][py] = 0; m_fl++; end
                     else if (m_fl > 0) begin m_flag[px][py] = 1; m_fl--; end
                  end
               end
            end
            default: if (bus.new_game) m_state = 0;
         endcase
      end
      px = bus.ind_x_in;
      py = bus.ind_y_in;
   end

   function automatic logic [255:0] pack_map(input bit want_flag);
      logic [255:0] v;
      v = '0;
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            v[x*16 + y] = want_flag ? m_flag[x][y] : m_rev[x][y];
      return v;
   endfunction

   always @(negedge clk) begin
      check("game_state",   256'(bus.game_state),   256'(m_state));
      check("flags_left",   256'(bus.flags_left),   256'(m_fl));
      check("elapsed_s",    256'(bus.elapsed_s),    256'(m_el));
      check("revealed_map", bus.revealed_map,       pack_map(1'b0));
      check("flag_map",     bus.flag_map,           pack_map(1'b1));
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic clear_pulses();
      bus.start = 0; bus.new_game = 0; bus.explode = 0; bus.defuse = 0; bus.mark_flag = 0;
   endtask

   task automatic do_reset();
      rst = 1; cyc(); rst = 0;
   endtask

   task automatic start_game(input int l);
      bus.level = 2'(l); bus.start = 1; cyc(); bus.start = 0;
   endtask

   task automatic new_game();
      bus.new_game = 1; cyc(); bus.new_game = 0;
   endtask

   // Indices one cycle ahead of the pulse, matching the mine-check latency
   task automatic pulse(input int x, input int y, input bit e, input bit d, input bit f);
      bus.ind_x_in = 4'(x); bus.ind_y_in = 4'(y);
      cyc();
      bus.explode = e; bus.defuse = d; bus.mark_flag = f;
      cyc();
      bus.explode = 0; bus.defuse = 0; bus.mark_flag = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1; bus.level = 0; bus.ind_x_in = 0; bus.ind_y_in = 0;
      clear_pulses();
      cyc(); cyc();
      rst = 0;
      check("rst_state", 256'(bus.game_state), 256'(0));
      check("rst_flags", 256'(bus.flags_left), 256'(0));

      start_game(0);
      check("start_lvl0_ignored", 256'(bus.game_state), 256'(0));
      start_game(1);
      check("start_play", 256'(bus.game_state), 256'(1));
      check("start_flags10", 256'(bus.flags_left), 256'(10));
      check("start_maps0", bus.revealed_map | bus.flag_map, 256'(0));
      do_reset();
      check("rst_mid_play", 256'(bus.game_state), 256'(0));
      check("rst_mid_flags", 256'(bus.flags_left), 256'(0));

      start_game(1);
      pulse(2, 3, 0, 1, 0);
      check("defuse_2_3", 256'(bus.revealed_map[2][3]), 256'(1));
      pulse(2, 3, 0, 1, 0);
      pulse(5, 5, 1, 0, 0);
      check("explode_lost", 256'(bus.game_state), 256'(3));
      pulse(1, 1, 0, 1, 0);
      check("lost_defuse_ignored", 256'(bus.revealed_map[1][1]), 256'(0));
      pulse(6, 6, 0, 0, 1);
      check("lost_flag_ignored", 256'(bus.flag_map[6][6]), 256'(0));
      new_game();
      check("new_game_idle", 256'(bus.game_state), 256'(0));

      start_game(1);
      for (int i = 0; i < 54; i++) pulse(i % 8, i / 8, 0, 1, 0);
      check("win_not_yet", 256'(bus.game_state), 256'(1));
      cyc();
      check("win_state", 256'(bus.game_state), 256'(2));
      repeat (30) cyc();
      check("won_elapsed_frozen", 256'(bus.elapsed_s), 256'(10));

      new_game();
      start_game(1);
      for (int i = 0; i < 10; i++) pulse(i % 8, i / 8, 0, 0, 1);
      check("flags_used_up", 256'(bus.flags_left), 256'(0));
      pulse(7, 7, 0, 0, 1);
      check("flag11_ignored", 256'(bus.flag_map[7][7]), 256'(0));
      pulse(0, 0, 0, 0, 1);
      check("unflag_cleared", 256'(bus.flag_map[0][0]), 256'(0));
      check("unflag_flags1", 256'(bus.flags_left), 256'(1));
      pulse(1, 1, 0, 1, 0);
      check("defuse_on_flag", 256'(bus.revealed_map[1][1]), 256'(0));
      pulse(1, 1, 1, 0, 0);
      check("explode_on_flag", 256'(bus.game_state), 256'(1));
      pulse(3, 3, 1, 1, 0);
      check("explode_beats_defuse", 256'(bus.game_state), 256'(3));

      new_game();
      start_game(1);
      pulse(9, 0, 0, 1, 0);
      check("out_of_range", 256'(bus.revealed_map[9][0]), 256'(0));
      do_reset();
      start_game(3);
      pulse(15, 15, 0, 1, 0);
      check("hard_15_15", 256'(bus.revealed_map[15][15]), 256'(1));

      do_reset();
      start_game(1);
      repeat (10000) cyc();
      check("elapsed_sat", 256'(bus.elapsed_s), 256'(999));
      for (int i = 0; i < 54; i++) pulse(i % 8, i / 8, 0, 1, 0);
      cyc();
      check("sat_won", 256'(bus.game_state), 256'(2));
      new_game();
      check("idle_keeps_elapsed", 256'(bus.elapsed_s), 256'(999));
      start_game(1);
      check("restart_elapsed0", 256'(bus.elapsed_s), 256'(0));

      for (int k = 0; k < 20000; k++) begin
         rst              = ($urandom_range(0, 1999) == 0);
         bus.level        = 2'($urandom_range(0, 3));
         bus.start        = ($urandom_range(0, 29) == 0);
         bus.new_game     = ($urandom_range(0, 19) == 0);
         bus.ind_x_in     = 4'($urandom_range(0, 15));
         bus.ind_y_in     = 4'($urandom_range(0, 15));
         bus.explode      = ($urandom_range(0, 399) == 0);
         bus.defuse       = ($urandom_range(0, 2) == 0);
         bus.mark_flag    = ($urandom_range(0, 5) == 0);
         cyc();
      end
      rst = 0;
      clear_pulses();
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
